// File: rtl/uart_text_cmd_parser.sv
// rtl/uart_text_cmd_parser.sv - ASCII "w DD AAAA" / "r AAAA" line parser driving a simple register bus
// Read responses are sent back as two uppercase hex digits followed by CR LF.
module uart_text_cmd_parser #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          new_rx_data,
    output logic [7:0]    tx_data,
    output logic          new_tx_data,
    input  logic          tx_busy,
    output logic [AW-1:0] int_address,
    output logic [DW-1:0] int_wr_data,
    output logic          int_write,
    output logic          int_read,
    input  logic          int_gnt,
    input  logic [DW-1:0] int_rd_data,
    output logic          rx_overrun
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CMD_SP  = 4'd1;
    localparam logic [3:0] S_FIELD1  = 4'd2;
    localparam logic [3:0] S_SEP     = 4'd3;
    localparam logic [3:0] S_FIELD2  = 4'd4;
    localparam logic [3:0] S_SKIP    = 4'd5;
    localparam logic [3:0] S_BUS_REQ = 4'd6;
    localparam logic [3:0] S_TX_HI   = 4'd7;
    localparam logic [3:0] S_TX_LO   = 4'd8;
    localparam logic [3:0] S_TX_CR   = 4'd9;
    localparam logic [3:0] S_TX_LF   = 4'd10;

    localparam logic [7:0] A_MAX = 8'(AW / 4);
    localparam logic [7:0] D_MAX = 8'(DW / 4);

    logic [3:0]    state_q, state_d;
    logic          op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          new_tx_q, new_tx_d;
    logic          sent_q, sent_d;
    logic          wait_q, wait_d;

    logic [3:0] ps;
    logic       is_sep, is_term, is_w, is_r, is_hex;
    logic [3:0] nib;
    logic [7:0] tx_byte;
    logic       overrun_c;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        is_sep  = (rx_data == 8'h20) || (rx_data == 8'h09);
        is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_w    = (rx_data == 8'h77) || (rx_data == 8'h57);
        is_r    = (rx_data == 8'h72) || (rx_data == 8'h52);
        is_hex  = 1'b1;
        nib     = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39)      nib = 4'(rx_data - 8'h30);
        else if (rx_data >= 8'h41 && rx_data <= 8'h46) nib = 4'(rx_data - 8'h37);
        else if (rx_data >= 8'h61 && rx_data <= 8'h66) nib = 4'(rx_data - 8'h57);
        else                                           is_hex = 1'b0;
    end

    always_comb begin
        case (state_q)
            S_TX_HI: tx_byte = to_ascii(rdata_q[7:4]);
            S_TX_LO: tx_byte = to_ascii(rdata_q[3:0]);
            S_TX_CR: tx_byte = 8'h0D;
            default: tx_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        rdata_d   = rdata_q;
        tx_data_d = tx_data_q;
        new_tx_d  = 1'b0;
        sent_d    = sent_q;
        wait_d    = wait_q;

        if (state_q == S_BUS_REQ) begin
            if (wr_q || rd_q) begin
                if (int_gnt) begin
                    wr_d = 1'b0;
                    rd_d = 1'b0;
                    if (op_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rdata_d = int_rd_data;
                        sent_d  = 1'b0;
                        wait_d  = 1'b0;
                        state_d = S_TX_HI;
                    end
                end
            end else begin
                wr_d = op_q;
                rd_d = !op_q;
            end
        end else if (state_q >= S_TX_HI) begin
            if (!sent_q) begin
                if (!tx_busy) begin
                    new_tx_d  = 1'b1;
                    tx_data_d = tx_byte;
                    sent_d    = 1'b1;
                    wait_d    = 1'b0;
                end
            end else if (!new_tx_q) begin
                // Move on once the UART has shown busy, or after one spare cycle if it never does.
                if (tx_busy || wait_q) begin
                    sent_d  = 1'b0;
                    wait_d  = 1'b0;
                    state_d = (state_q == S_TX_LF) ? S_IDLE : state_q + 4'd1;
                end else begin
                    wait_d = 1'b1;
                end
            end
        end

        // A byte arriving as the busy phase hands back to IDLE is parsed as if already in IDLE.
        ps        = (state_q >= S_BUS_REQ) ? state_d : state_q;
        overrun_c = new_rx_data && (ps >= S_BUS_REQ);

        if (new_rx_data && ps < S_BUS_REQ) begin
            case (ps)
                S_IDLE: begin
                    if (is_w || is_r) begin
                        op_d    = is_w;
                        addr_d  = '0;
                        data_d  = '0;
                        cnt_d   = 8'd0;
                        state_d = S_CMD_SP;
                    end else if (is_term) state_d = S_IDLE;
                    else                  state_d = S_SKIP;
                end
                S_CMD_SP: begin
                    if (is_hex) begin
                        if (op_q) data_d = {{(DW-4){1'b0}}, nib};
                        else      addr_d = {{(AW-4){1'b0}}, nib};
                        cnt_d   = 8'd1;
                        state_d = S_FIELD1;
                    end else if (is_term)  state_d = S_IDLE;
                    else if (!is_sep)      state_d = S_SKIP;
                end
                S_FIELD1: begin
                    if (is_hex) begin
                        if (cnt_q == (op_q ? D_MAX : A_MAX)) begin
                            state_d = S_SKIP;
                        end else begin
                            if (op_q) data_d = {data_q[DW-5:0], nib};
                            else      addr_d = {addr_q[AW-5:0], nib};
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (is_sep)  state_d = op_q ? S_SEP : S_SKIP;
                    else if (is_term)     state_d = op_q ? S_IDLE : S_BUS_REQ;
                    else                  state_d = S_SKIP;
                end
                S_SEP: begin
                    if (is_hex) begin
                        addr_d  = {{(AW-4){1'b0}}, nib};
                        cnt_d   = 8'd1;
                        state_d = S_FIELD2;
                    end else if (is_term)  state_d = S_IDLE;
                    else if (!is_sep)      state_d = S_SKIP;
                end
                S_FIELD2: begin
                    if (is_hex) begin
                        if (cnt_q == A_MAX) begin
                            state_d = S_SKIP;
                        end else begin
                            addr_d = {addr_q[AW-5:0], nib};
                            cnt_d  = cnt_q + 8'd1;
                        end
                    end else if (is_term)  state_d = S_BUS_REQ;
                    else                   state_d = S_SKIP;
                end
                default: begin
                    if (is_term) state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= 8'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            rdata_q   <= '0;
            tx_data_q <= 8'h00;
            new_tx_q  <= 1'b0;
            sent_q    <= 1'b0;
            wait_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rdata_q   <= rdata_d;
            tx_data_q <= tx_data_d;
            new_tx_q  <= new_tx_d;
            sent_q    <= sent_d;
            wait_q    <= wait_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign int_address = addr_q;
    assign int_wr_data = data_q;
    assign int_write   = wr_q;
    assign int_read    = rd_q;
    assign rx_overrun  = overrun_c;

endmodule

// File: tb/tb_uart_text_cmd_parser.sv
// tb/tb_uart_text_cmd_parser.sv - scoreboard bench for uart_text_cmd_parser
module tb_uart_text_cmd_parser;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        new_rx_data = 1'b0;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy = 1'b0;
    logic [15:0] int_address;
    logic [7:0]  int_wr_data;
    logic        int_write;
    logic        int_read;
    logic        int_gnt = 1'b0;
    logic [7:0]  int_rd_data = 8'h00;
    logic        rx_overrun;

    bus_item_t   exp_bus[$];
    logic [7:0]  exp_tx[$];

    int n_cmp = 0;
    int n_err = 0;
    int gnt_delay = 1;
    int busy_len = 4;
    logic [7:0] rd_val = 8'h00;
    int exp_ovr = 0;
    int ovr_cnt = 0;
    int chk_seq = 0;
    int chk_done = 0;
    int req_cnt = 0;
    int busy_cnt = 0;
    int since_rx = 100;
    logic gnt_prev = 1'b0;

    uart_text_cmd_parser #(.AW(16), .DW(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .int_address(int_address), .int_wr_data(int_wr_data),
        .int_write(int_write), .int_read(int_read), .int_gnt(int_gnt),
        .int_rd_data(int_rd_data), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    // Bus/UART responders plus the checking monitor, all sampled on the falling edge.
    always @(negedge clk) begin
        bus_item_t it;
        logic [7:0] eb;
        if (rst) begin
            n_cmp++;
            if ({int_write, int_read, new_tx_data, rx_overrun, tx_data, int_address, int_wr_data} != '0) begin
                n_err++;
                $display("FAIL reset_outputs: wr=%0b rd=%0b ntx=%0b ovr=%0b tx=%h addr=%h wd=%h, required all 0",
                         int_write, int_read, new_tx_data, rx_overrun, tx_data, int_address, int_wr_data);
            end
            int_gnt = 1'b0; gnt_prev = 1'b0; req_cnt = 0; tx_busy = 1'b0; busy_cnt = 0;
        end else begin
            if (new_rx_data) since_rx = 0; else since_rx++;
            if (rx_overrun) ovr_cnt++;

            if (gnt_prev) begin
                n_cmp++;
                if (int_write || int_read) begin
                    n_err++;
                    $display("FAIL req_drop: wr=%0b rd=%0b after grant, required 0", int_write, int_read);
                end
            end
            gnt_prev = 1'b0;
            int_gnt  = 1'b0;
            if (int_write && int_read) begin
                n_cmp++; n_err++;
                $display("FAIL req_both: write and read both high, required one");
            end
            if (int_write || int_read) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    n_cmp++;
                    if (since_rx != 2) begin
                        n_err++;
                        $display("FAIL req_latency: %0d cycles, required 2", since_rx);
                    end
                end
                if (req_cnt == gnt_delay) begin
                    int_gnt = 1'b1; gnt_prev = 1'b1; int_rd_data = rd_val;
                    n_cmp++;
                    if (exp_bus.size() == 0) begin
                        n_err++;
                        $display("FAIL bus_unexpected: we=%0b addr=%h, required no transaction", int_write, int_address);
                    end else begin
                        it = exp_bus.pop_front();
                        if (int_write != it.we || int_address != it.addr || (it.we && int_wr_data != it.data)) begin
                            n_err++;
                            $display("FAIL bus_txn: we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                                     int_write, int_address, int_wr_data, it.we, it.addr, it.data);
                        end
                    end
                end
            end else begin
                req_cnt = 0;
            end

            if (new_tx_data) begin
                n_cmp++;
                if (tx_busy) begin
                    n_err++;
                    $display("FAIL tx_while_busy: strobe with tx_busy=1, required 0");
                end
                n_cmp++;
                if (exp_tx.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_unexpected: byte %h, required none", tx_data);
                end else begin
                    eb = exp_tx.pop_front();
                    if (tx_data != eb) begin
                        n_err++;
                        $display("FAIL tx_byte: got %h, required %h", tx_data, eb);
                    end
                end
                if (busy_len > 0) begin tx_busy = 1'b1; busy_cnt = busy_len; end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end

            if (chk_seq != chk_done) begin
                chk_done = chk_seq;
                n_cmp++;
                if (exp_bus.size() != 0 || exp_tx.size() != 0) begin
                    n_err++;
                    $display("FAIL pending_%0d: bus=%0d tx=%0d left, required 0 0", chk_seq, exp_bus.size(), exp_tx.size());
                end
                n_cmp++;
                if (ovr_cnt != exp_ovr) begin
                    n_err++;
                    $display("FAIL overrun_%0d: count %0d, required %0d", chk_seq, ovr_cnt, exp_ovr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data = b; new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
    endtask

    task automatic send_cmd(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        send_byte(8'h0D);
    endtask

    task automatic push_bus(input logic we, input logic [15:0] a, input logic [7:0] d);
        bus_item_t it;
        it.we = we; it.addr = a; it.data = d;
        exp_bus.push_back(it);
    endtask

    task automatic push_resp(input logic [7:0] hi, input logic [7:0] lo);
        exp_tx.push_back(hi); exp_tx.push_back(lo);
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            tick();
            if (exp_bus.size() == 0 && exp_tx.size() == 0 && !int_read && !int_write) break;
        end
        repeat (20) tick();
        chk_seq++;
        repeat (2) tick();
    endtask

    string       err_cmd[4] = '{"x 12", "w 123 0", "r 12345", "w 12"};
    logic [7:0]  err_rd[4]  = '{8'h3C, 8'h9F, 8'h00, 8'hE5};
    logic [7:0]  err_hi[4]  = '{8'h33, 8'h39, 8'h30, 8'h45};
    logic [7:0]  err_lo[4]  = '{8'h43, 8'h46, 8'h30, 8'h35};

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        push_bus(1'b1, 16'h0000, 8'h01);
        send_cmd("w 01 0000");
        wait_idle();

        push_bus(1'b1, 16'h00FF, 8'h0A);
        send_cmd("W\t0A\t00FF");
        wait_idle();

        push_bus(1'b1, 16'h0001, 8'h16);
        send_cmd("w 16 0001");
        wait_idle();
        gnt_delay = 3; rd_val = 8'h16; busy_len = 4;
        push_bus(1'b0, 16'h0001, 8'h00);
        push_resp(8'h31, 8'h36);
        send_cmd("r 1");
        wait_idle();

        gnt_delay = 1; rd_val = 8'hAB; busy_len = 5;
        push_bus(1'b0, 16'h001A, 8'h00);
        push_resp(8'h41, 8'h42);
        send_cmd("r 1a");
        wait_idle();

        busy_len = 0;
        for (int k = 0; k < 4; k++) begin
            send_cmd(err_cmd[k]);
            repeat (4) tick();
            rd_val = err_rd[k];
            push_bus(1'b0, 16'h0000, 8'h00);
            push_resp(err_hi[k], err_lo[k]);
            send_cmd("R 0");
            wait_idle();
        end

        busy_len = 3; rd_val = 8'h7D;
        push_bus(1'b0, 16'h0055, 8'h00);
        push_resp(8'h37, 8'h44);
        send_cmd("r 55");
        for (int i = 0; i < 200; i++) begin
            if (new_tx_data) break;
            tick();
        end
        send_byte(8'h77); send_byte(8'h20); send_byte(8'h31);
        exp_ovr += 3;
        wait_idle();

        gnt_delay = 1000;
        send_cmd("r 2");
        for (int i = 0; i < 50; i++) begin
            if (int_read) break;
            tick();
        end
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        gnt_delay = 1; busy_len = 2; rd_val = 8'h42;
        repeat (2) tick();
        push_bus(1'b0, 16'h0000, 8'h00);
        push_resp(8'h34, 8'h32);
        send_cmd("r 0");
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
